// File: rtl/sub_serial_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
// Keeps state encoding and chunk/counter arithmetic in one place.
package sub_serial_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int chunks(input int width, input int bpc);
      return width / bpc;
   endfunction

   // A single-chunk build still needs a 1-bit counter to exist.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic bit cfg_ok(input int width, input int bpc);
      return (bpc > 0) && (bpc <= width) && ((width % bpc) == 0);
   endfunction

endpackage

// File: rtl/sub_chunk.sv
// Combinational BPC-bit ripple subtractor: d = x - y - bi, bo = borrow out of the MSB.
// Zero latency; no flow control.
module sub_chunk #(
   parameter int BPC = 1
) (
   input  logic [BPC-1:0] x,
   input  logic [BPC-1:0] y,
   input  logic           bi,
   output logic [BPC-1:0] d,
   output logic           bo
);

   logic br;

   always_comb begin
      d  = '0;
      br = bi;
      for (int i = 0; i < BPC; i++) begin
         d[i] = x[i] ^ y[i] ^ br;
         br   = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & br);
      end
      bo = br;
   end

endmodule

// File: rtl/sub8_serial.sv
// Bit-serial a = s - b mod 2^WIDTH with borrow flag, LSB chunk first, BPC bits per cycle.
// Latency WIDTH/BPC cycles from accept to out_valid; one op in flight, out_ready low holds DONE.
module sub8_serial
   import sub_serial_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int BPC   = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] s,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] a,
   output logic             borrow
);

   localparam int N  = chunks(WIDTH, BPC);
   localparam int CW = cnt_width(N);

   generate
      if (!cfg_ok(WIDTH, BPC)) begin : g_bad_cfg
         $error("sub8_serial: BPC must divide WIDTH");
      end
   endgenerate

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] s_sr;
   logic [WIDTH-1:0] b_sr;
   logic [BPC-1:0]   d;
   logic             bo;

   sub_chunk #(.BPC(BPC)) u_chunk (
      .x  (s_sr[BPC-1:0]),
      .y  (b_sr[BPC-1:0]),
      .bi (borrow),
      .d  (d),
      .bo (bo)
   );

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         s_sr   <= '0;
         b_sr   <= '0;
         a      <= '0;
         borrow <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  s_sr   <= s;
                  b_sr   <= b;
                  cnt    <= '0;
                  borrow <= 1'b0;
                  state  <= RUN;
               end
            end
            RUN: begin
               // Result chunks enter at the top so chunk 0 lands in the LSBs after N shifts.
               a      <= WIDTH'({d, a} >> BPC);
               s_sr   <= s_sr >> BPC;
               b_sr   <= b_sr >> BPC;
               borrow <= bo;
               cnt    <= cnt + 1'b1;
               if (cnt == CW'(N - 1)) begin
                  state <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sub8_serial.sv
// Directed bench for sub8_serial: a BPC=1 instance and a BPC=2 instance share reset and clock.
module tb_sub8_serial;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       sel = 1'b0;
   logic       iv  = 1'b0;
   logic       ordy = 1'b0;
   logic [7:0] sv  = '0;
   logic [7:0] bv  = '0;

   logic       ir1, ov1, br1, ir2, ov2, br2;
   logic [7:0] a1, a2;
   logic       iv1, iv2, or1, or2;

   assign iv1 = iv & ~sel;
   assign iv2 = iv &  sel;
   assign or1 = ordy & ~sel;
   assign or2 = ordy &  sel;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sub8_serial #(.WIDTH(8), .BPC(1)) u_dut (
      .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .s(sv), .b(bv),
      .out_valid(ov1), .out_ready(or1), .a(a1), .borrow(br1)
   );

   sub8_serial #(.WIDTH(8), .BPC(2)) u_dut2 (
      .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .s(sv), .b(bv),
      .out_valid(ov2), .out_ready(or2), .a(a2), .borrow(br2)
   );

   function automatic logic cur_ir();  return sel ? ir2 : ir1; endfunction
   function automatic logic cur_ov();  return sel ? ov2 : ov1; endfunction
   function automatic logic cur_br();  return sel ? br2 : br1; endfunction
   function automatic logic [7:0] cur_a(); return sel ? a2 : a1; endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer one pair, return cycles from the accepting edge until out_valid is seen.
   task automatic start_op(input logic [7:0] s_i, input logic [7:0] b_i, output int lat);
      sv = s_i;
      bv = b_i;
      iv = 1'b1;
      tick();
      iv = 1'b0;
      lat = 0;
      while (!cur_ov() && lat < 40) begin
         tick();
         lat++;
      end
   endtask

   task automatic finish_op();
      ordy = 1'b1;
      tick();
      ordy = 1'b0;
   endtask

   task automatic full_op(input string tag, input logic [7:0] s_i, input logic [7:0] b_i,
                          input logic [7:0] a_exp, input logic br_exp, input int lat_exp);
      int lat;
      start_op(s_i, b_i, lat);
      check({tag, "_lat"}, lat, lat_exp);
      check({tag, "_a"}, cur_a(), a_exp);
      check({tag, "_borrow"}, cur_br(), br_exp);
      finish_op();
      check({tag, "_in_ready_after"}, cur_ir(), 1'b1);
   endtask

   initial begin
      int lat;
      logic [7:0] x, y;
      logic [8:0] sum;

      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      check("rst_in_ready", ir1, 1'b1);
      check("rst_out_valid", ov1, 1'b0);
      check("rst_a", a1, 8'd0);
      check("rst_borrow", br1, 1'b0);

      full_op("basic", 8'd200, 8'd100, 8'd100, 1'b0, 8);
      full_op("wrap5_7", 8'd5, 8'd7, 8'd254, 1'b1, 8);
      full_op("wrap0_255", 8'd0, 8'd255, 8'd1, 1'b1, 8);
      full_op("equal255", 8'd255, 8'd255, 8'd0, 1'b0, 8);

      // Round trip through the forward adder model on a sample of pairs.
      for (int i = 0; i < 40; i++) begin
         x = 8'($urandom_range(0, 255));
         y = 8'($urandom_range(0, 255));
         if (i == 0) begin x = 8'd255; y = 8'd1; end
         if (i == 1) begin x = 8'd128; y = 8'd128; end
         sum = {1'b0, x} + {1'b0, y};
         start_op(sum[7:0], y, lat);
         check("rt_a", cur_a(), x);
         check("rt_borrow", cur_br(), sum[8]);
         finish_op();
      end

      // Backpressure: result must hold while out_ready stays low.
      start_op(8'd37, 8'd12, lat);
      for (int i = 0; i < 10; i++) begin
         tick();
         check("bp_a", a1, 8'd25);
         check("bp_borrow", br1, 1'b0);
         check("bp_in_ready", ir1, 1'b0);
         check("bp_out_valid", ov1, 1'b1);
      end
      finish_op();

      // Operand change and in_valid pulse during RUN are ignored.
      sv = 8'd50;
      bv = 8'd20;
      iv = 1'b1;
      tick();
      iv = 1'b0;
      tick();
      sv = 8'd1;
      bv = 8'd2;
      iv = 1'b1;
      check("ign_in_ready", ir1, 1'b0);
      tick();
      iv = 1'b0;
      lat = 2;
      while (!ov1 && lat < 40) begin
         tick();
         lat++;
      end
      check("ign_lat", lat, 8);
      check("ign_a", a1, 8'd30);
      check("ign_borrow", br1, 1'b0);
      finish_op();

      // Reset after chunk 3 of 200-100 discards the operation.
      sv = 8'd200;
      bv = 8'd100;
      iv = 1'b1;
      tick();
      iv = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mrst_in_ready", ir1, 1'b1);
      check("mrst_out_valid", ov1, 1'b0);
      check("mrst_a", a1, 8'd0);
      check("mrst_borrow", br1, 1'b0);
      lat = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (ov1) lat++;
      end
      check("mrst_no_out_valid", lat, 0);
      full_op("post_rst", 8'd9, 8'd4, 8'd5, 1'b0, 8);

      // Two bits per cycle build.
      sel = 1'b1;
      check("bpc2_idle", ir2, 1'b1);
      full_op("bpc2", 8'd5, 8'd7, 8'd254, 1'b1, 4);
      full_op("bpc2_basic", 8'd200, 8'd100, 8'd100, 1'b0, 4);
      sel = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
